// File: rtl/oven_pkg.sv
// Shared types and constants for the oven sequencing controller.
package oven_pkg;

    // Debug-visible state encoding.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCook  = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } oven_state_e;

    localparam int unsigned TickDivDefault    = 50_000_000;
    localparam int unsigned BuzzCyclesDefault = 100_000_000;
    localparam int unsigned TimerWidth        = 8;

    // Counter width that stays at least one bit wide for tiny ranges.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/oven_tick_gen.sv
// Countdown-tick prescaler: counts completed cook cycles modulo TICK_DIV.
// The count holds while run is low, so a partially elapsed tick survives a pause.
module oven_tick_gen
    import oven_pkg::*;
#(
    parameter int unsigned TICK_DIV = TickDivDefault
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned     CntW    = $clog2(TICK_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear on a fresh start, otherwise advance once per cook cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
        end
    end

    // The upcoming cycle is the last of a tick period; the caller registers this.
    assign tick = (cnt_d == CntLast);

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/oven_ctrl_fsm.sv
// Oven sequencing controller: start/cancel/door handling, countdown tick
// generation for the external timer, heater/light/buzzer drive.
// Optional feature macro: OVEN_DOOR_LOCK_EN (adds door_lock, door ignored in COOK).
module oven_ctrl_fsm
    import oven_pkg::*;
#(
    parameter int unsigned TICK_DIV    = TickDivDefault,
    parameter int unsigned BUZZ_CYCLES = BuzzCyclesDefault
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cancel,
    input  logic                  door_open,
    input  logic [TimerWidth-1:0] timer_val,
    output logic                  timer_en,
    output logic                  heater,
    output logic                  light,
    output logic                  buzzer,
    output logic                  done,
`ifdef OVEN_DOOR_LOCK_EN
    output logic                  door_lock,
`endif
    output logic [1:0]            state
);

    localparam int unsigned      BuzzW    = cnt_width(BUZZ_CYCLES);
    localparam logic [BuzzW-1:0] BuzzLast = BuzzW'(BUZZ_CYCLES - 1);

    oven_state_e      state_q, state_d;
    logic [BuzzW-1:0] buzz_q, buzz_d;
    logic             timer_zero, door_evt;
    logic             tick, tick_run, tick_clear;
    logic             heater_d, light_d, buzzer_d, done_d, timer_en_d;
    logic             heater_q, light_q, buzzer_q, done_q, timer_en_q;

    assign timer_zero = (timer_val == '0);

`ifdef OVEN_DOOR_LOCK_EN
    // Door is latched shut while cooking, so it never interrupts COOK.
    assign door_evt = 1'b0;
`else
    assign door_evt = door_open;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in COOK cancel beats door, door beats timer expiry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && !door_open && !timer_zero) state_d = StCook;
            end
            StCook: begin
                if (cancel)          state_d = StIdle;
                else if (door_evt)   state_d = StPause;
                else if (timer_zero) state_d = StDone;
            end
            StPause: begin
                if (cancel)                  state_d = StIdle;
                else if (start && !door_open) state_d = StCook;
            end
            StDone: begin
                if (cancel || (buzz_q == BuzzLast)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Buzzer counter runs only while staying in DONE; zero on every entry.
    always_comb begin
        buzz_d = '0;
        if (state_q == StDone && state_d == StDone) buzz_d = buzz_q + BuzzW'(1);
    end

    // Buzzer counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buzz_q <= '0;
        end else begin
            buzz_q <= buzz_d;
        end
    end

    assign tick_run   = (state_q == StCook);
    assign tick_clear = (state_q == StIdle) && (state_d == StCook);

    oven_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .run   (tick_run),
        .clear (tick_clear),
        .tick  (tick)
    );

    // Output decode from the upcoming state so registered outputs move with it;
    // gating the tick with the next state drops a tick when COOK is left.
    always_comb begin
        heater_d   = (state_d == StCook);
        light_d    = (state_d == StCook) || (state_d == StPause);
        buzzer_d   = (state_d == StDone);
        done_d     = (state_d == StDone) && (state_q != StDone);
        timer_en_d = tick && (state_d == StCook);
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            heater_q   <= 1'b0;
            light_q    <= 1'b0;
            buzzer_q   <= 1'b0;
            done_q     <= 1'b0;
            timer_en_q <= 1'b0;
        end else begin
            heater_q   <= heater_d;
            light_q    <= light_d;
            buzzer_q   <= buzzer_d;
            done_q     <= done_d;
            timer_en_q <= timer_en_d;
        end
    end

`ifdef OVEN_DOOR_LOCK_EN
    logic door_lock_q;

    // Door lock follows the cooking state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            door_lock_q <= 1'b0;
        end else begin
            door_lock_q <= (state_d == StCook);
        end
    end

    assign door_lock = door_lock_q;
`endif

    assign heater   = heater_q;
    assign light    = light_q;
    assign buzzer   = buzzer_q;
    assign done     = done_q;
    assign timer_en = timer_en_q;
    assign state    = state_q;

endmodule

// File: tb/tb_oven_ctrl_fsm.sv
// Bench for oven_ctrl_fsm with a small cook-time model and a countdown timer model.
module tb_oven_ctrl_fsm;

    localparam int TD = 4;
    localparam int BC = 3;

    logic       clk = 1'b0;
    logic       rst, start, cancel, door_open;
    logic [7:0] timer_val;
    logic       timer_en, heater, light, buzzer, done;
    logic [1:0] state;
`ifdef OVEN_DOOR_LOCK_EN
    logic       door_lock;
`endif

    int checks = 0;
    int failures = 0;

    // Model: spec state number, completed COOK cycles, DONE cycles, timer value.
    int m_state, m_cook, m_buzz, tv;
    bit e_en, e_done;
    int n_en, n_heat, n_buzz, n_done;
    int k;

    always #5 clk = ~clk;

    oven_ctrl_fsm #(
        .TICK_DIV    (TD),
        .BUZZ_CYCLES (BC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cancel    (cancel),
        .door_open (door_open),
        .timer_val (timer_val),
        .timer_en  (timer_en),
        .heater    (heater),
        .light     (light),
        .buzzer    (buzzer),
        .done      (done),
`ifdef OVEN_DOOR_LOCK_EN
        .door_lock (door_lock),
`endif
        .state     (state)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cook  = 0;
        m_buzz  = 0;
        e_en    = 1'b0;
        e_done  = 1'b0;
    endtask

    // One clock edge of the behavioural model, using the inputs seen at that edge.
    task automatic model_step();
        int ns;
        bit door_cook;
        if (rst) begin
            model_reset();
            return;
        end
`ifdef OVEN_DOOR_LOCK_EN
        door_cook = 1'b0;
`else
        door_cook = door_open;
`endif
        ns = m_state;
        case (m_state)
            0: if (start && !door_open && timer_val != 8'd0) ns = 1;
            1: begin
                if (cancel) ns = 0;
                else if (door_cook) ns = 2;
                else if (timer_val == 8'd0) ns = 3;
            end
            2: begin
                if (cancel) ns = 0;
                else if (start && !door_open) ns = 1;
            end
            default: if (cancel || m_buzz >= BC) ns = 0;
        endcase
        // The external timer counts down on the edge that ends a tick cycle.
        if (e_en && tv > 0) tv--;
        if (m_state == 1) m_cook++;
        if (m_state == 0 && ns == 1) m_cook = 0;
        // Tick lands on every TD-th cycle of accumulated cook time.
        e_en   = (ns == 1) && (((m_cook + 1) % TD) == 0);
        e_done = (ns == 3) && (m_state != 3);
        m_buzz = (ns == 3) ? ((m_state == 3) ? m_buzz + 1 : 1) : 0;
        m_state = ns;
    endtask

    task automatic compare();
        check("state", int'(state), m_state);
        check("heater", int'(heater), int'(m_state == 1));
        check("light", int'(light), int'(m_state == 1 || m_state == 2));
        check("buzzer", int'(buzzer), int'(m_state == 3));
        check("done", int'(done), int'(e_done));
        check("timer_en", int'(timer_en), int'(e_en));
`ifdef OVEN_DOOR_LOCK_EN
        check("door_lock", int'(door_lock), int'(m_state == 1));
`endif
        n_en   += int'(timer_en);
        n_heat += int'(heater);
        n_buzz += int'(buzzer);
        n_done += int'(done);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        timer_val = 8'(tv);
    endtask

    task automatic set_tv(input int v);
        tv = v;
        timer_val = 8'(v);
    endtask

    task automatic clear_counts();
        n_en = 0; n_heat = 0; n_buzz = 0; n_done = 0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cancel = 1'b0; door_open = 1'b0;
        set_tv(0);
        model_reset();
        clear_counts();
        repeat (2) cycle();
        check("reset_state", int'(state), 0);
        check("reset_heater", int'(heater), 0);
        check("reset_timer_en", int'(timer_en), 0);
        rst = 1'b0;

        // Normal cook of three ticks.
        clear_counts();
        set_tv(3); start = 1'b1; cycle(); start = 1'b0;
        repeat (20) cycle();
        check("normal_en_pulses", n_en, 3);
        check("normal_heater_cycles", n_heat, 13);
        check("normal_done_pulses", n_done, 1);
        check("normal_buzzer_cycles", n_buzz, 3);
        check("normal_back_idle", int'(state), 0);

        // Start blocked by an empty timer or an open door.
        clear_counts();
        set_tv(0); start = 1'b1; repeat (3) cycle();
        set_tv(5); door_open = 1'b1; repeat (3) cycle();
        start = 1'b0; door_open = 1'b0;
        check("blocked_heater", n_heat, 0);
        check("blocked_en", n_en, 0);
        check("blocked_state", int'(state), 0);

`ifndef OVEN_DOOR_LOCK_EN
        // Door pause preserves the partial tick.
        set_tv(5); start = 1'b1; cycle(); start = 1'b0; cycle();
        door_open = 1'b1; cycle();
        check("pause_state", int'(state), 2);
        check("pause_light", int'(light), 1);
        check("pause_heater", int'(heater), 0);
        repeat (3) cycle();
        check("pause_prescaler_held", int'(dut.u_tick_gen.cnt_q), 2);
        door_open = 1'b0; start = 1'b1; cycle(); start = 1'b0;
        k = 1;
        while (timer_en !== 1'b1 && k < 10) begin
            cycle();
            k++;
        end
        check("resume_tick_delay", k, 2);
        cancel = 1'b1; cycle(); cancel = 1'b0;
        check("pause_cancel_idle", int'(state), 0);

        // Door and expiry together: pause first, finish on resume.
        set_tv(1); start = 1'b1; cycle(); start = 1'b0;
        repeat (4) cycle();
        door_open = 1'b1; cycle();
        check("zero_door_pause", int'(state), 2);
        door_open = 1'b0; start = 1'b1; cycle(); start = 1'b0;
        cycle();
        check("zero_resume_done", int'(state), 3);
        repeat (4) cycle();
`else
        // Locked door: opening it does not interrupt cooking.
        clear_counts();
        set_tv(2); start = 1'b1; cycle(); start = 1'b0; cycle();
        door_open = 1'b1; cycle();
        check("lock_state_cook", int'(state), 1);
        check("lock_door_lock", int'(door_lock), 1);
        repeat (15) cycle();
        door_open = 1'b0;
        check("lock_done_pulses", n_done, 1);
        check("lock_en_pulses", n_en, 2);
        check("lock_back_idle", int'(state), 0);
`endif

        // Cancel outranks door in COOK.
        set_tv(5); start = 1'b1; cycle(); start = 1'b0; cycle();
        cancel = 1'b1; door_open = 1'b1; cycle();
        cancel = 1'b0; door_open = 1'b0;
        check("cancel_over_door", int'(state), 0);
        check("cancel_heater", int'(heater), 0);

        // Cancel during the buzzer.
        set_tv(1); start = 1'b1; cycle(); start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 30) begin
            cycle();
            k++;
        end
        check("done_reached", int'(done), 1);
        cancel = 1'b1; cycle(); cancel = 1'b0;
        check("cancel_done_buzzer", int'(buzzer), 0);
        check("cancel_done_state", int'(state), 0);

        // Asynchronous reset in the middle of a tick cycle.
        set_tv(5); start = 1'b1; cycle(); start = 1'b0;
        repeat (3) cycle();
        check("pre_reset_tick", int'(timer_en), 1);
        #2 rst = 1'b1;
        #1;
        check("async_heater", int'(heater), 0);
        check("async_light", int'(light), 0);
        check("async_timer_en", int'(timer_en), 0);
        check("async_state", int'(state), 0);
        model_reset();
        cycle();
        rst = 1'b0;
        repeat (2) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
